// File: rtl/cpu_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_loader_pkg
// Purpose  : Shared definitions for the cpu program loader: command byte
//            values, loader FSM state encoding and header length.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package cpu_loader_pkg;

    localparam logic [7:0] CMD_IMEM = 8'h49;  // 'I' load instruction memory
    localparam logic [7:0] CMD_DMEM = 8'h44;  // 'D' load data memory
    localparam logic [7:0] CMD_GO   = 8'h47;  // 'G' start the cpu
    localparam logic [7:0] CMD_HALT = 8'h48;  // 'H' stop the cpu (only meaningful in RUN)

    localparam int HDR_BYTES = 4;             // base lo/hi, count lo/hi

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        RUN   = 3'd5
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_program_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_packer
// Purpose  : Collects bytes into a little-endian 32-bit word. The word is
//            presented combinationally together with the 4th byte so the
//            parent can capture it on the same edge that accepts that byte.
// Ports    : clk, rst         clock / synchronous active-high reset
//            i_clear          discard any partial word
//            i_valid, i_byte  byte strobe and value
//            o_word           {i_byte, bytes 2..0}, valid when o_word_ready
//            o_word_ready     i_valid on the 4th byte of a word
// Revision : 1.0  initial release
// ============================================================================
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_ready
);

    // Bytes shift in from the top so that after three bytes the first one
    // sits in bits [7:0].
    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_valid) begin
            r_shift <= {i_byte, r_shift[23:8]};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

    assign o_word       = {i_byte, r_shift};
    assign o_word_ready = i_valid && (r_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/cpu_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : cpu_program_loader
// Purpose  : Boot/loader stage in front of the pipelined cpu. Decodes load
//            commands from a valid/ready byte stream, packs data into 32-bit
//            words and writes them through the cpu external imem/dmem write
//            ports. 'G' starts the cpu, 'H' stops it; no load can happen
//            while the cpu is enabled.
// Ports    : clk, rst                    clock / synchronous active-high reset
//            in_valid, in_data, in_ready byte stream input
//            imem_addr/wen/wdata         cpu instruction-memory write port
//            dmem_addr/wen/wdata         cpu data-memory write port
//            cpu_enable                  cpu run enable
//            load_done                   pulse after a segment completes
//            cmd_error                   pulse on an unknown command byte
// Revision : 1.0  initial release
// ============================================================================
module cpu_program_loader
    import cpu_loader_pkg::*;
#(
    parameter int ADDR_STEP = 4,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [31:0] imem_addr,
    output logic        imem_wen,
    output logic [31:0] imem_wdata,
    output logic [31:0] dmem_addr,
    output logic        dmem_wen,
    output logic [31:0] dmem_wdata,
    output logic        cpu_enable,
    output logic        load_done,
    output logic        cmd_error
);

    loader_state_t r_state;
    loader_state_t w_state_next;

    logic [1:0]       r_hdr_cnt;
    logic [7:0]       r_hdr_lo;     // low byte of the header field being assembled
    logic [CNT_W-1:0] r_count;      // words still to be written
    logic             r_sel_dmem;
    logic [31:0]      r_addr;       // address of the next word to write
    logic [31:0]      r_imem_addr;
    logic [31:0]      r_imem_wdata;
    logic [31:0]      r_dmem_addr;
    logic [31:0]      r_dmem_wdata;
    logic             r_cmd_error;

    logic             w_in_ready;
    logic             w_accept;
    logic [15:0]      w_hdr_field;
    logic [31:0]      w_word;
    logic             w_word_ready;
    logic             w_imem_wen;
    logic             w_dmem_wen;
    logic             w_load_done;
    logic             w_cpu_enable;

    assign w_accept    = in_valid && w_in_ready;
    assign w_hdr_field = {in_data, r_hdr_lo};

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (r_state != DATA),
        .i_valid      (w_accept && (r_state == DATA)),
        .i_byte       (in_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_imem_wen   = 1'b0;
        w_dmem_wen   = 1'b0;
        w_load_done  = 1'b0;
        w_cpu_enable = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (w_accept) begin
                    if (in_data == CMD_IMEM || in_data == CMD_DMEM) begin
                        w_state_next = HDR;
                    end else if (in_data == CMD_GO) begin
                        w_state_next = RUN;
                    end
                end
            end
            HDR: begin
                w_in_ready = 1'b1;
                if (w_accept && (r_hdr_cnt == 2'(HDR_BYTES - 1))) begin
                    w_state_next = (w_hdr_field == 16'd0) ? DONE : DATA;
                end
            end
            DATA: begin
                w_in_ready = 1'b1;
                if (w_accept && w_word_ready) begin
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                w_imem_wen   = !r_sel_dmem;
                w_dmem_wen   = r_sel_dmem;
                w_state_next = (r_count == CNT_W'(1)) ? DONE : DATA;
            end
            DONE: begin
                w_load_done  = 1'b1;
                w_state_next = IDLE;
            end
            RUN: begin
                w_in_ready   = 1'b1;
                w_cpu_enable = 1'b1;
                if (w_accept && (in_data == CMD_HALT)) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Header capture, address generation and write-port registers.
    // addr/wdata are loaded on the edge that accepts the 4th byte so they
    // are stable during the WRITE cycle and hold afterwards.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr_cnt    <= '0;
            r_hdr_lo     <= '0;
            r_count      <= '0;
            r_sel_dmem   <= 1'b0;
            r_addr       <= '0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_cmd_error  <= 1'b0;
        end else begin
            r_cmd_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_hdr_cnt <= '0;
                    if (w_accept) begin
                        if (in_data == CMD_IMEM) begin
                            r_sel_dmem <= 1'b0;
                        end else if (in_data == CMD_DMEM) begin
                            r_sel_dmem <= 1'b1;
                        end else if (in_data != CMD_GO) begin
                            r_cmd_error <= 1'b1;
                        end
                    end
                end
                HDR: begin
                    if (w_accept) begin
                        r_hdr_cnt <= r_hdr_cnt + 2'd1;
                        case (r_hdr_cnt)
                            2'd0:    r_hdr_lo <= in_data;
                            2'd1:    r_addr   <= 32'(w_hdr_field);
                            2'd2:    r_hdr_lo <= in_data;
                            default: r_count  <= CNT_W'(w_hdr_field);
                        endcase
                    end
                end
                DATA: begin
                    if (w_accept && w_word_ready) begin
                        if (r_sel_dmem) begin
                            r_dmem_addr  <= r_addr;
                            r_dmem_wdata <= w_word;
                        end else begin
                            r_imem_addr  <= r_addr;
                            r_imem_wdata <= w_word;
                        end
                    end
                end
                WRITE: begin
                    r_addr  <= r_addr + 32'(ADDR_STEP);
                    r_count <= r_count - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign imem_addr  = r_imem_addr;
    assign imem_wen   = w_imem_wen;
    assign imem_wdata = r_imem_wdata;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wen   = w_dmem_wen;
    assign dmem_wdata = r_dmem_wdata;
    assign cpu_enable = w_cpu_enable;
    assign load_done  = w_load_done;
    assign cmd_error  = r_cmd_error;

endmodule
`default_nettype wire

// File: tb/tb_cpu_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_program_loader
// Purpose  : Self-checking bench for cpu_program_loader. Frames are built
//            from random and directed content; expected memory writes are
//            computed from the frame contents and compared in order.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
    logic        imem_wen, dmem_wen, cpu_enable, load_done, cmd_error;

    cpu_program_loader #(.ADDR_STEP(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_addr  (imem_addr),
        .imem_wen   (imem_wen),
        .imem_wdata (imem_wdata),
        .dmem_addr  (dmem_addr),
        .dmem_wen   (dmem_wen),
        .dmem_wdata (dmem_wdata),
        .cpu_enable (cpu_enable),
        .load_done  (load_done),
        .cmd_error  (cmd_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          dmem;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  r_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   acc_cyc  = -10;
    int   last_evt = -10;
    int   done_cnt = 0;
    int   err_cnt  = 0;
    int   wen_cnt  = 0;
    bit   gap_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Event monitor: every write must match the next expected write, appear
    // one cycle after the last byte of its word, and never while running.
    always @(negedge clk) begin
        if (imem_wen || dmem_wen) begin
            wen_cnt++;
            check("wen_both", 32'(imem_wen & dmem_wen), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexp_wen", 32'd1, 32'd0);
            end else begin
                r_e = exp_q.pop_front();
                check("wen_port", 32'(dmem_wen), 32'(r_e.dmem));
                check("wen_addr", dmem_wen ? dmem_addr : imem_addr, r_e.addr);
                check("wen_data", dmem_wen ? dmem_wdata : imem_wdata, r_e.data);
                check("wen_lat", 32'(cyc), 32'(acc_cyc + 1));
                check("wen_cpu_en", 32'(cpu_enable), 32'd0);
            end
            last_evt = cyc;
        end
        if (load_done) begin
            done_cnt++;
            check("done_lat", 32'(cyc), 32'(last_evt + 1));
            last_evt = cyc;
        end
        if (cmd_error) err_cnt++;
        if (in_valid && in_ready && !rst) begin
            acc_cyc  = cyc;
            last_evt = cyc;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present one byte, wait (bounded) for it to be taken.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        if (gap_en) repeat ($urandom_range(0, 3)) sync();
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 32'd0, 32'd1);
        sync();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_cnt > d0) break;
        end
        check("done_seen", 32'(done_cnt), 32'(d0 + 1));
        check("all_writes", 32'(exp_q.size()), 32'd0);
        sync();
    endtask

    // Reference: word n goes to zero-extended base + 4*n, bytes little-endian.
    task automatic load_frame(input logic [7:0] cmd, input logic [15:0] base,
                              input logic [31:0] words[$]);
        int          d0;
        logic [31:0] w;
        wr_t         e;
        d0 = done_cnt;
        send_byte(cmd);
        send_byte(base[7:0]);
        send_byte(base[15:8]);
        send_byte(8'(words.size()));
        send_byte(8'(words.size() >> 8));
        for (int n = 0; n < words.size(); n++) begin
            w      = words[n];
            e.dmem = (cmd == 8'h44);
            e.addr = {16'd0, base} + 32'(n) * 32'd4;
            e.data = w;
            exp_q.push_back(e);
            for (int k = 0; k < 4; k++) send_byte(8'(w >> (8 * k)));
        end
        wait_done(d0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) sync();
        rst = 1'b0;
    endtask

    logic [31:0] words[$];
    int          wc0, ec0;

    initial begin
        // 1: reset values
        sync();
        do_reset();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_outs", 32'({imem_wen, dmem_wen, cpu_enable, load_done, cmd_error}), 32'd0);
        check("rst_imem", imem_addr | imem_wdata, 32'd0);
        check("rst_dmem", dmem_addr | dmem_wdata, 32'd0);
        check("rst_nowen", 32'(wen_cnt), 32'd0);
        sync();

        // 2: directed imem load
        words = '{32'h12345678, 32'hDEADBEEF};
        load_frame(8'h49, 16'h0100, words);

        // 3: empty dmem load, then gapped single-word dmem load
        wc0 = wen_cnt;
        words.delete();
        load_frame(8'h44, 16'h0000, words);
        check("cnt0_nowen", 32'(wen_cnt), 32'(wc0));
        gap_en = 1'b1;
        words = '{$urandom};
        load_frame(8'h44, 16'h0000, words);
        gap_en = 1'b0;

        // 4: go / ignore while running / halt / bad command
        ec0 = err_cnt;
        @(negedge clk);
        check("pre_go_en", 32'(cpu_enable), 32'd0);
        sync();
        send_byte(8'h47);
        @(negedge clk);
        check("go_en", 32'(cpu_enable), 32'd1);
        sync();
        send_byte(8'h49);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (b == 8'h48) b = 8'h00;
            send_byte(b);
        end
        @(negedge clk);
        check("run_en_hold", 32'(cpu_enable), 32'd1);
        check("run_no_err", 32'(err_cnt), 32'(ec0));
        sync();
        send_byte(8'h48);
        @(negedge clk);
        check("halt_en", 32'(cpu_enable), 32'd0);
        sync();
        send_byte(8'h5A);
        @(negedge clk);
        check("bad_cmd_err", 32'(cmd_error), 32'd1);
        sync();
        @(negedge clk);
        check("err_pulse", 32'(err_cnt), 32'(ec0 + 1));
        sync();

        // 5: base crossing 16 bits
        words = '{$urandom, $urandom};
        load_frame(8'h49, 16'hFFFC, words);

        // 6: reset in the middle of a word
        wc0 = wen_cnt;
        send_byte(8'h49);
        send_byte(8'h20); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        do_reset();
        repeat (3) sync();
        check("rst_mid_nowen", 32'(wen_cnt), 32'(wc0));
        @(negedge clk);
        check("rst_mid_ready", 32'(in_ready), 32'd1);
        sync();
        words = '{32'hCAFEF00D};
        load_frame(8'h49, 16'h0040, words);

        // Random frames
        for (int f = 0; f < 6; f++) begin
            int cnt;
            gap_en = 1'($urandom);
            cnt = $urandom_range(1, 4);
            words.delete();
            for (int n = 0; n < cnt; n++) words.push_back($urandom);
            load_frame(($urandom_range(0, 1) != 0) ? 8'h44 : 8'h49, 16'($urandom), words);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
